regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback (WB) stage and the multi-cycle mult/div unit (MDU).
- Pipeline writes have priority. MDU results are queued in a small FIFO, and a starvation limit guarantees they drain.
- A 32-entry pending scoreboard tracks destinations of issued MDU ops and raises a read-hazard stall toward decode.
- Sits between WB/MDU and the register file. Drives its wr_en, wr_addr, wr_data and JAL inputs.

---
 rtl/regfile_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and queued MDU results; rf_* one cycle after grant.
// MDU backpressure via mdu_ready (FIFO full); WB held only on forced drains. Optional RF_ARB_BYPASS_EN: idle-port MDU bypass.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wr_en,
    input  logic        pipe_jal,
    input  logic [4:0]  pipe_wr_addr,
    input  logic [31:0] pipe_wr_data,
    output logic        pipe_hold,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wr_addr,
    input  logic [31:0] mdu_wr_data,
    input  logic        issue_en,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic        raw_stall,
    output logic        rf_wr_en,
    output logic        rf_jal,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t        state;
    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;

    logic        empty;
    logic        full;
    logic        push;
    logic        push_fifo;
    logic        pop;
    logic        bypass;
    logic        grant_pipe;
    logic        losing;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        head_addr  = fifo_addr[rd_ptr];
        head_data  = fifo_data[rd_ptr];
        push       = mdu_valid && !full;
        bypass     = 1'b0;
`ifdef RF_ARB_BYPASS_EN
        bypass     = (state == NORMAL) && empty && !pipe_wr_en && push;
`endif
        push_fifo  = push && !bypass;
        grant_pipe = (state == NORMAL) && pipe_wr_en;
        // In FORCE the head wins regardless of WB; in NORMAL only an idle WB lets it through.
        pop        = !empty && ((state == FORCE) || !pipe_wr_en);
        losing     = (state == NORMAL) && !empty && !pop;
        set_mask   = (issue_en && issue_addr != 5'd0) ? (32'd1 << issue_addr) : 32'd0;
        clr_mask   = 32'd0;
        if (pop)
            clr_mask = 32'd1 << head_addr;
        else if (bypass)
            clr_mask = 32'd1 << mdu_wr_addr;
    end

    assign mdu_ready = !full;
    assign pipe_hold = (state == FORCE) && pipe_wr_en;
    assign raw_stall = (rd_addr0 != 5'd0 && pending[rd_addr0])
                    || (rd_addr1 != 5'd0 && pending[rd_addr1])
                    || (issue_en && issue_addr != 5'd0
                        && (issue_addr == rd_addr0 || issue_addr == rd_addr1));

    always_ff @(posedge clk) begin
        if (push_fifo) begin
            fifo_addr[wr_ptr] <= mdu_wr_addr;
            fifo_data[wr_ptr] <= mdu_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NORMAL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pending    <= '0;
            rf_wr_en   <= 1'b0;
            rf_jal     <= 1'b0;
            rf_wr_addr <= 5'd0;
            rf_wr_data <= 32'd0;
        end else begin
            if (push_fifo)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count + (AW+1)'(push_fifo) - (AW+1)'(pop);
            // OR-ing the set mask last makes a same-cycle issue win over a clear.
            pending <= (pending & ~clr_mask) | set_mask;

            case (state)
                NORMAL: begin
                    if (pop) begin
                        starve_cnt <= '0;
                    end else if (losing) begin
                        starve_cnt <= starve_cnt + SW'(1);
                        if (starve_cnt + SW'(1) == LIMIT)
                            state <= FORCE;
                    end
                end
                FORCE: begin
                    state      <= NORMAL;
                    starve_cnt <= '0;
                end
            endcase

            rf_wr_en <= 1'b0;
            rf_jal   <= 1'b0;
            if (grant_pipe) begin
                rf_wr_en   <= pipe_jal || (pipe_wr_addr != 5'd0);
                rf_jal     <= pipe_jal;
                rf_wr_addr <= pipe_jal ? 5'd31 : pipe_wr_addr;
                rf_wr_data <= pipe_wr_data;
            end else if (pop) begin
                rf_wr_en   <= (head_addr != 5'd0);
                rf_wr_addr <= head_addr;
                rf_wr_data <= head_data;
            end else if (bypass) begin
                rf_wr_en   <= (mdu_wr_addr != 5'd0);
                rf_wr_addr <= mdu_wr_addr;
                rf_wr_data <= mdu_wr_data;
            end
        end
    end

    issue_to_pending: assert property (@(posedge clk) disable iff (rst)
        !(issue_en && issue_addr != 5'd0 && pending[issue_addr]));

    force_needs_entry: assert property (@(posedge clk) disable iff (rst)
        (state == FORCE) |-> !empty);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wr_en, pipe_jal, mdu_valid, issue_en;
    logic [4:0]  pipe_wr_addr, mdu_wr_addr, issue_addr, rd_addr0, rd_addr1;
    logic [31:0] pipe_wr_data, mdu_wr_data;
    logic        pipe_hold, mdu_ready, raw_stall, rf_wr_en, rf_jal;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wr_en(pipe_wr_en), .pipe_jal(pipe_jal), .pipe_wr_addr(pipe_wr_addr),
        .pipe_wr_data(pipe_wr_data), .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wr_addr(mdu_wr_addr),
        .mdu_wr_data(mdu_wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .raw_stall(raw_stall),
        .rf_wr_en(rf_wr_en), .rf_jal(rf_jal), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model: queued results, pending set, consecutive losses, expected rf outputs.
    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_losses;
    logic        e_ready, e_hold, e_stall, e_en, e_jal;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        o_ready, o_hold, o_stall, o_en, o_jal;
    logic [4:0]  o_addr;
    logic [31:0] o_data;
    logic [41:0] ov, ev;

    task automatic idle();
        pipe_wr_en = 0; pipe_jal = 0; pipe_wr_addr = 0; pipe_wr_data = 0;
        mdu_valid = 0; mdu_wr_addr = 0; mdu_wr_data = 0;
        issue_en = 0; issue_addr = 0; rd_addr0 = 0; rd_addr1 = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 32'd0; m_losses = 0;
        e_en = 0; e_jal = 0; e_addr = 0; e_data = 0;
    endtask

    // One clock cycle: sample combinational outputs mid-cycle, advance model, sample rf_* after the edge.
    task automatic step();
        ent_t h;
        logic acc, byp, frc;
        #2;
        frc     = (m_losses >= STARVE_LIMIT);
        e_ready = (mq.size() < DEPTH);
        e_hold  = frc && pipe_wr_en;
        e_stall = (rd_addr0 != 0 && m_pend[rd_addr0]) || (rd_addr1 != 0 && m_pend[rd_addr1])
               || (issue_en && issue_addr != 0 && (issue_addr == rd_addr0 || issue_addr == rd_addr1));
        o_ready = mdu_ready; o_hold = pipe_hold; o_stall = raw_stall;
        acc = mdu_valid && e_ready;
        byp = 1'b0;
`ifdef RF_ARB_BYPASS_EN
        byp = !frc && mq.size() == 0 && !pipe_wr_en && acc;
`endif
        e_en = 0; e_jal = 0;
        if (mq.size() > 0 && (frc || !pipe_wr_en)) begin
            h = mq.pop_front();
            e_en = (h.a != 0); e_addr = h.a; e_data = h.d;
            m_pend[h.a] = 1'b0;
            m_losses = 0;
        end else if (pipe_wr_en && !frc) begin
            e_jal  = pipe_jal;
            e_en   = pipe_jal || pipe_wr_addr != 0;
            e_addr = pipe_jal ? 5'd31 : pipe_wr_addr;
            e_data = pipe_wr_data;
            if (mq.size() > 0) m_losses++;
        end else if (byp) begin
            e_en = (mdu_wr_addr != 0); e_addr = mdu_wr_addr; e_data = mdu_wr_data;
            m_pend[mdu_wr_addr] = 1'b0;
        end
        if (acc && !byp) mq.push_back({mdu_wr_addr, mdu_wr_data});
        if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        @(posedge clk);
        #1;
        o_en = rf_wr_en; o_jal = rf_jal; o_addr = rf_wr_addr; o_data = rf_wr_data;
        ov = {o_ready, o_hold, o_stall, o_en, o_jal, o_addr, o_data};
        ev = {e_ready, e_hold, e_stall, e_en, e_jal, e_addr, e_data};
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; model_reset();
        @(posedge clk); #1;
        total++;
        if ({rf_wr_en, rf_jal, rf_wr_addr, rf_wr_data, pipe_hold, raw_stall, mdu_ready} !== {40'd0, 1'b1}) begin
            bad++; $display("FAIL reset_outputs got %h exp %h",
                {rf_wr_en, rf_jal, rf_wr_addr, rf_wr_data, pipe_hold, raw_stall, mdu_ready}, {40'd0, 1'b1});
        end
        rst = 1'b0;
        step();
        total++;
        if ({o_en, o_jal, o_addr, o_data} !== 39'd0) begin
            bad++; $display("FAIL after_reset_idle got %h exp 0", {o_en, o_jal, o_addr, o_data});
        end
    endtask

    task automatic test_pipe_write();
        idle(); pipe_wr_en = 1; pipe_wr_addr = 5; pipe_wr_data = 32'hDEADBEEF;
        step();
        total++; if (ov !== ev) begin bad++; $display("FAIL pipe_model got %h exp %h", ov, ev); end
        total++;
        if ({o_en, o_jal, o_addr, o_data} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}) begin
            bad++; $display("FAIL pipe_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", o_en, o_addr, o_data);
        end
        idle(); step();
        total++; if (o_en !== 1'b0) begin bad++; $display("FAIL pipe_one_cycle got en=%b exp 0", o_en); end
    endtask

    task automatic test_jal();
        idle(); pipe_wr_en = 1; pipe_jal = 1; pipe_wr_addr = 7; pipe_wr_data = 32'h400;
        step();
        total++; if (ov !== ev) begin bad++; $display("FAIL jal_model got %h exp %h", ov, ev); end
        total++;
        if ({o_en, o_jal, o_addr, o_data} !== {1'b1, 1'b1, 5'd31, 32'h400}) begin
            bad++; $display("FAIL jal_write got en=%b jal=%b addr=%0d exp en=1 jal=1 addr=31", o_en, o_jal, o_addr);
        end
        pipe_jal = 0; pipe_wr_addr = 0; pipe_wr_data = 32'h1111;
        step();
        total++; if ({o_en, o_jal} !== 2'b00) begin bad++; $display("FAIL addr0_write got en=%b jal=%b exp 0 0", o_en, o_jal); end
        idle(); step();
    endtask

    task automatic test_raw_hazard();
        bit got;
        idle(); issue_en = 1; issue_addr = 9; rd_addr0 = 9;
        step();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL raw_issue_fwd got %b exp 1", o_stall); end
        issue_en = 0;
        repeat (2) begin
            step();
            total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL raw_pending got %b exp 1", o_stall); end
        end
        mdu_valid = 1; mdu_wr_addr = 9; mdu_wr_data = 32'h12345678;
        step();
        total++; if (ov !== ev) begin bad++; $display("FAIL raw_push_model got %h exp %h", ov, ev); end
        mdu_valid = 0;
        got = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_en) begin got = 1; break; end
            step();
        end
        total++;
        if (!got || o_addr !== 5'd9 || o_data !== 32'h12345678) begin
            bad++; $display("FAIL raw_result_write got seen=%0d addr=%0d data=%h exp addr=9 data=12345678", got, o_addr, o_data);
        end
        step();
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL raw_release got %b exp 0", o_stall); end
        idle();
    endtask

    task automatic test_starvation();
        int hold_at;
        logic [31:0] pd;
        idle(); pipe_wr_en = 1; pipe_wr_addr = 1;
        for (int i = 0; i < 4; i++) begin
            mdu_valid = 1; mdu_wr_addr = 5'(10 + i); mdu_wr_data = 32'hA0000000 + i;
            pipe_wr_data = $urandom;
            step();
            total++; if (ov !== ev) begin bad++; $display("FAIL fill_model[%0d] got %h exp %h", i, ov, ev); end
        end
        mdu_wr_addr = 20; pipe_wr_data = $urandom;
        step();
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b exp 0", o_ready); end
        mdu_valid = 0;
        hold_at = -1;
        for (int i = 0; i < 20; i++) begin
            pipe_wr_data = $urandom;
            step();
            total++; if (ov !== ev) begin bad++; $display("FAIL starve_model[%0d] got %h exp %h", i, ov, ev); end
            if (o_hold) begin hold_at = i; break; end
        end
        total++;
        if (hold_at != 4 || o_en !== 1'b1 || o_addr !== 5'd10 || o_data !== 32'hA0000000) begin
            bad++; $display("FAIL forced_drain got hold_at=%0d addr=%0d data=%h exp hold_at=4 addr=10 data=a0000000", hold_at, o_addr, o_data);
        end
        pd = pipe_wr_data;
        step();
        total++;
        if (o_en !== 1'b1 || o_addr !== 5'd1 || o_data !== pd || o_hold !== 1'b0) begin
            bad++; $display("FAIL pipe_after_force got en=%b addr=%0d data=%h hold=%b exp 1 1 %h 0", o_en, o_addr, o_data, o_hold, pd);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (o_addr !== 5'(11 + i) || o_data !== 32'hA0000001 + i) begin
                bad++; $display("FAIL drain_order[%0d] got addr=%0d data=%h exp addr=%0d", i, o_addr, o_data, 11 + i);
            end
        end
    endtask

    task automatic test_push_pop();
        idle(); pipe_wr_en = 1; pipe_wr_addr = 2;
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1; mdu_wr_addr = 5'(16 + i); mdu_wr_data = $urandom; pipe_wr_data = $urandom;
            step();
        end
        pipe_wr_en = 0;
        for (int i = 0; i < 10; i++) begin
            mdu_wr_addr = 5'(16 + ((i + 3) % 8)); mdu_wr_data = $urandom;
            step();
            total++; if (ov !== ev) begin bad++; $display("FAIL pushpop_model[%0d] got %h exp %h", i, ov, ev); end
            total++;
            if (o_ready !== 1'b1 || o_en !== 1'b1 || o_addr !== 5'(16 + (i % 8))) begin
                bad++; $display("FAIL pushpop[%0d] got ready=%b en=%b addr=%0d exp 1 1 %0d", i, o_ready, o_en, o_addr, 16 + (i % 8));
            end
        end
        mdu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ov !== ev) begin bad++; $display("FAIL pushpop_drain[%0d] got %h exp %h", i, ov, ev); end
        end
    endtask

    task automatic test_reset_mid();
        idle(); pipe_wr_en = 1; pipe_wr_addr = 3;
        for (int i = 0; i < 3; i++) begin
            issue_en = 1; issue_addr = 5'(21 + i);
            mdu_valid = 1; mdu_wr_addr = 5'(21 + i); mdu_wr_data = $urandom; pipe_wr_data = $urandom;
            step();
        end
        issue_en = 0; mdu_valid = 0; rd_addr0 = 21;
        step();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got %b exp 1", o_stall); end
        idle(); rd_addr0 = 21; rd_addr1 = 23;
        rst = 1'b1; model_reset();
        #2;
        total++;
        if ({rf_wr_en, raw_stall, mdu_ready, pipe_hold} !== 4'b0010) begin
            bad++; $display("FAIL async_reset got en/stall/ready/hold=%b exp 0010", {rf_wr_en, raw_stall, mdu_ready, pipe_hold});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (ov !== ev || o_en !== 1'b0 || o_stall !== 1'b0) begin
                bad++; $display("FAIL post_reset[%0d] got %h exp %h", i, ov, ev);
            end
        end
    endtask

    task automatic test_idle_mdu();
        idle(); mdu_valid = 1; mdu_wr_addr = 3; mdu_wr_data = 32'hCAFE0003;
        step();
        mdu_valid = 0;
        total++; if (ov !== ev) begin bad++; $display("FAIL idle_mdu_model got %h exp %h", ov, ev); end
`ifdef RF_ARB_BYPASS_EN
        total++;
        if (o_en !== 1'b1 || o_addr !== 5'd3 || o_data !== 32'hCAFE0003) begin
            bad++; $display("FAIL bypass_latency got en=%b addr=%0d exp en=1 addr=3", o_en, o_addr);
        end
`else
        total++; if (o_en !== 1'b0) begin bad++; $display("FAIL queue_latency1 got en=%b exp 0", o_en); end
        step();
        total++;
        if (o_en !== 1'b1 || o_addr !== 5'd3 || o_data !== 32'hCAFE0003) begin
            bad++; $display("FAIL queue_latency2 got en=%b addr=%0d exp en=1 addr=3", o_en, o_addr);
        end
`endif
        step();
    endtask

    task automatic test_random();
        logic held;
        int pct;
        logic [4:0] a;
        held = 0;
        for (int i = 0; i < 400; i++) begin
            pct = ((i / 100) % 2 == 0) ? 90 : 30;
            if (!held) begin
                pipe_wr_en   = ($urandom_range(0, 99) < pct);
                pipe_jal     = ($urandom_range(0, 7) == 0);
                pipe_wr_addr = 5'($urandom_range(0, 31));
                pipe_wr_data = $urandom;
            end
            mdu_valid   = $urandom_range(0, 1) != 0;
            mdu_wr_addr = 5'($urandom_range(0, 31));
            mdu_wr_data = $urandom;
            a = 5'($urandom_range(0, 31));
            issue_addr = a;
            issue_en   = ($urandom_range(0, 2) == 0) && !m_pend[a];
            rd_addr0   = 5'($urandom_range(0, 31));
            rd_addr1   = 5'($urandom_range(0, 31));
            step();
            total++; if (ov !== ev) begin bad++; $display("FAIL random[%0d] got %h exp %h", i, ov, ev); end
            held = o_hold;
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_pipe_write();
        test_jal();
        test_raw_hazard();
        test_starvation();
        test_push_pop();
        test_reset_mid();
        test_idle_mdu();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
